// File: rtl/kgp_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter:
// FSM encoding, requester IDs and default widths.
package kgp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mux2_cell.sv
// Generic 2:1 mux cell used in front of the shared memory port.
module mux2_cell #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin chooser: a lone request wins outright,
// a tie goes to the requester that was not granted last.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       any,
  output logic       winner
);

  assign any    = |valid;
  assign winner = (&valid) ? ~last : valid[1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between
// instruction fetch (0) and the load/store unit (1), one access at a time.
module mem_port_arbiter
  import kgp_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sel
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT=%0d outside 1..15", MEM_LAT);
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              last_grant_reg, sel_reg;
  logic              any, winner, transfer, capture;
  logic [1:0]        valid_vec, we_vec, ready_vec, rvalid_vec, we_lat;
  logic [ADDR_W-1:0] addr_in [2];
  logic [ADDR_W-1:0] addr_lat [2];
  logic [DATA_W-1:0] wdata_in [2];
  logic [DATA_W-1:0] wdata_lat [2];
  logic [DATA_W-1:0] rdata_out [2];

  assign valid_vec   = {req1_valid, req0_valid};
  assign we_vec      = {req1_we, req0_we};
  assign addr_in[0]  = req0_addr;
  assign addr_in[1]  = req1_addr;
  assign wdata_in[0] = req0_wdata;
  assign wdata_in[1] = req1_wdata;

  rr_pick2 u_pick (
    .valid  (valid_vec),
    .last   (last_grant_reg),
    .any    (any),
    .winner (winner)
  );

  assign transfer = (state_reg == IDLE) && any;
  assign capture  = (state_reg == WAIT) && (cnt_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= REQ_LS;
      sel_reg        <= REQ_IF;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (transfer) begin
        sel_reg        <= winner;
        last_grant_reg <= winner;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE:  if (transfer) state_next = ISSUE;
      ISSUE: begin
        cnt_next   = CNT_INIT;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = RESP;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each requester keeps its own request and response slot; sel picks the live one.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              mine;

    assign mine = (sel_reg == 1'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        we_reg    <= 1'b0;
        addr_reg  <= '0;
        wdata_reg <= '0;
        rdata_reg <= '0;
      end else begin
        if (transfer && (winner == 1'(gi))) begin
          we_reg    <= we_vec[gi];
          addr_reg  <= addr_in[gi];
          wdata_reg <= wdata_in[gi];
        end
        if (capture && mine) rdata_reg <= we_reg ? '0 : mem_rdata;
      end
    end

    // Gated by rst_n so ready drops together with every other output.
    assign ready_vec[gi]  = rst_n && (state_reg == IDLE) && any && (winner == 1'(gi));
    assign rvalid_vec[gi] = (state_reg == RESP) && mine;
    assign we_lat[gi]     = we_reg;
    assign addr_lat[gi]   = addr_reg;
    assign wdata_lat[gi]  = wdata_reg;
    assign rdata_out[gi]  = rdata_reg;

    a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (valid_vec[gi] && !ready_vec[gi]) |=> valid_vec[gi]);
  end

  mux2_cell #(.W(ADDR_W)) u_addr_mux (
    .sel (sel_reg),
    .in0 (addr_lat[0]),
    .in1 (addr_lat[1]),
    .out (mem_addr)
  );

  mux2_cell #(.W(DATA_W)) u_wdata_mux (
    .sel (sel_reg),
    .in0 (wdata_lat[0]),
    .in1 (wdata_lat[1]),
    .out (mem_wdata)
  );

  assign mem_en      = (state_reg == ISSUE);
  assign mem_we      = mem_en && (sel_reg ? we_lat[1] : we_lat[0]);
  assign sel         = sel_reg;
  assign req0_ready  = ready_vec[0];
  assign req1_ready  = ready_vec[1];
  assign req0_rvalid = rvalid_vec[0];
  assign req1_rvalid = rvalid_vec[1];
  assign req0_rdata  = rdata_out[0];
  assign req1_rdata  = rdata_out[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter (MEM_LAT=2) plus
// MEM_LAT=1 and MEM_LAT=15 instances for the latency extremes.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        v0;
    logic        we0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        v1;
    logic        we1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        win;
    logic [31:0] rdata;
  } txn_t;

  localparam int LATS [3] = '{2, 1, 15};

  logic        clk, rst_n;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [31:0] req0_rdata, req1_rdata;
  logic        mem_we, sel;
  logic [31:0] mem_wdata;

  logic        mem_en_w    [3];
  logic [31:0] mem_addr_w  [3];
  logic [31:0] mem_rdata_w [3];

  logic        lv;
  logic [31:0] la;
  logic        lat_ready0 [2], lat_ready1 [2], lat_rvalid0 [2], lat_rvalid1 [2];
  logic        lat_mem_we [2], lat_sel [2];
  logic [31:0] lat_rdata0 [2], lat_rdata1 [2], lat_mem_wdata [2];

  logic        sr_v [3][16];
  logic [31:0] sr_a [3][16];

  int passed = 0;
  int total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_en(mem_en_w[0]), .mem_we(mem_we), .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata_w[0]), .sel(sel)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    mem_port_arbiter #(.MEM_LAT(gi == 0 ? 1 : 15)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(lv), .req0_we(1'b0), .req0_addr(la), .req0_wdata(32'd0),
      .req0_ready(lat_ready0[gi]), .req0_rvalid(lat_rvalid0[gi]), .req0_rdata(lat_rdata0[gi]),
      .req1_valid(1'b0), .req1_we(1'b0), .req1_addr(32'd0), .req1_wdata(32'd0),
      .req1_ready(lat_ready1[gi]), .req1_rvalid(lat_rvalid1[gi]), .req1_rdata(lat_rdata1[gi]),
      .mem_en(mem_en_w[gi+1]), .mem_we(lat_mem_we[gi]), .mem_addr(mem_addr_w[gi+1]),
      .mem_wdata(lat_mem_wdata[gi]), .mem_rdata(mem_rdata_w[gi+1]), .sel(lat_sel[gi])
    );
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hFFFF0000);
  endfunction

  // Memory model: data is valid only exactly LAT cycles after mem_en, garbage otherwise.
  initial begin
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 16; k++) begin
        sr_v[d][k] = 1'b0;
        sr_a[d][k] = 32'd0;
      end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      sr_v[d][0] <= mem_en_w[d];
      sr_a[d][0] <= mem_addr_w[d];
      for (int k = 1; k < 16; k++) begin
        sr_v[d][k] <= sr_v[d][k-1];
        sr_a[d][k] <= sr_a[d][k-1];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      mem_rdata_w[d] = 32'hBADBAD00;
      if (sr_v[d][LATS[d]-1]) mem_rdata_w[d] = mem_fn(sr_a[d][LATS[d]-1]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ctrl"}, 32'({mem_en_w[0], mem_we, sel, req0_ready, req1_ready,
                               req0_rvalid, req1_rvalid}), 32'd0);
    check({tag, " mem_addr"}, mem_addr_w[0], 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " rdata0"}, req0_rdata, 32'd0);
    check({tag, " rdata1"}, req1_rdata, 32'd0);
  endtask

  // Expects the DUT idle at the next falling edge; drives one record and follows it to RESP.
  task automatic run_txn(input txn_t t, input int idx);
    int k;
    logic [31:0] exp_addr, exp_wdata;
    logic exp_we;
    @(negedge clk);
    req0_valid = t.v0; req0_we = t.we0; req0_addr = t.a0; req0_wdata = t.d0;
    req1_valid = t.v1; req1_we = t.we1; req1_addr = t.a1; req1_wdata = t.d1;
    rst_n = 1'b1;
    #1;
    check($sformatf("t%0d ready0", idx), 32'(req0_ready), 32'(t.win == 1'b0));
    check($sformatf("t%0d ready1", idx), 32'(req1_ready), 32'(t.win == 1'b1));
    @(posedge clk);
    #1;
    if (t.win) req1_valid = 1'b0;
    else       req0_valid = 1'b0;
    exp_addr  = t.win ? t.a1 : t.a0;
    exp_wdata = t.win ? t.d1 : t.d0;
    exp_we    = t.win ? t.we1 : t.we0;
    @(negedge clk);
    check($sformatf("t%0d mem_en", idx), 32'(mem_en_w[0]), 32'd1);
    check($sformatf("t%0d mem_we", idx), 32'(mem_we), 32'(exp_we));
    check($sformatf("t%0d mem_addr", idx), mem_addr_w[0], exp_addr);
    check($sformatf("t%0d mem_wdata", idx), mem_wdata, exp_wdata);
    check($sformatf("t%0d sel", idx), 32'(sel), 32'(t.win));
    check($sformatf("t%0d busy ready", idx), 32'({req1_ready, req0_ready}), 32'd0);
    k = 0;
    while (k < 20 && !(req0_rvalid || req1_rvalid)) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("t%0d issue->rvalid cycles", idx), 32'(k), 32'd3);
    check($sformatf("t%0d rvalid pair", idx), 32'({req1_rvalid, req0_rvalid}),
          t.win ? 32'd2 : 32'd1);
    check($sformatf("t%0d rdata", idx), t.win ? req1_rdata : req0_rdata, t.rdata);
  endtask

  initial begin
    txn_t tbl [11];
    int k1, k15;
    logic [31:0] rd1, rd15;

    rst_n = 1'b0; lv = 1'b0; la = 32'd0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 32'd0; req0_wdata = 32'd0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 32'd0; req1_wdata = 32'd0;

    //            v0  we0  a0           d0            v1  we1  a1           d1            win   rdata
    tbl[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 1'b0, 32'h300, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b0, 32'h200, 32'h0,        1'b1, 1'b0, 32'h300, 32'h0,        1'b1, 32'hFFFF0300};
    tbl[2]  = '{1'b1, 1'b0, 32'h200, 32'h0,        1'b1, 1'b0, 32'h304, 32'h0,        1'b0, 32'hFFFF0200};
    tbl[3]  = '{1'b1, 1'b1, 32'h010, 32'h11112222, 1'b1, 1'b0, 32'h304, 32'h0,        1'b1, 32'hFFFF0304};
    tbl[4]  = '{1'b1, 1'b1, 32'h010, 32'h11112222, 1'b1, 1'b0, 32'h308, 32'h0,        1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 1'b0, 32'h308, 32'h0,        1'b1, 32'hFFFF0308};
    tbl[6]  = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hFFFF0400};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h040, 32'hA5A5A5A5, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h044, 32'h0,        1'b1, 32'hFFFF0044};
    tbl[9]  = '{1'b1, 1'b0, 32'h500, 32'h0,        1'b1, 1'b0, 32'h048, 32'h0,        1'b0, 32'hFFFF0500};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h048, 32'h0,        1'b1, 32'hFFFF0048};

    repeat (2) @(negedge clk);
    check_zero("reset");

    for (int i = 0; i < 11; i++) run_txn(tbl[i], i);

    // Reset in the middle of a read: everything clears at once and no response follows.
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h600;
    #1;
    check("abort ready0", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h704;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    repeat (2) begin
      @(negedge clk);
      check("abort no rvalid", 32'({req1_rvalid, req0_rvalid}), 32'd0);
    end
    run_txn('{1'b1, 1'b0, 32'h700, 32'h0, 1'b1, 1'b0, 32'h704, 32'h0, 1'b0, 32'hFFFF0700}, 20);
    run_txn('{1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h704, 32'h0, 1'b1, 32'hFFFF0704}, 21);

    // Latency extremes: MEM_LAT=1 and MEM_LAT=15 accept the same read together.
    @(negedge clk);
    lv = 1'b1; la = 32'h800;
    #1;
    check("lat1 ready0", 32'(lat_ready0[0]), 32'd1);
    check("lat15 ready0", 32'(lat_ready0[1]), 32'd1);
    @(posedge clk);
    #1;
    lv = 1'b0;
    k1 = 0; k15 = 0; rd1 = 32'd0; rd15 = 32'd0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (lat_rvalid0[0] && k1 == 0) begin k1 = k; rd1 = lat_rdata0[0]; end
      if (lat_rvalid0[1] && k15 == 0) begin k15 = k; rd15 = lat_rdata0[1]; end
    end
    check("lat1 accept->rvalid", 32'(k1), 32'd3);
    check("lat15 accept->rvalid", 32'(k15), 32'd17);
    check("lat1 rdata", rd1, 32'hFFFF0800);
    check("lat15 rdata", rd15, 32'hFFFF0800);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("lat%0d idle req1 side", g), 32'({lat_ready1[g], lat_rvalid1[g],
            lat_mem_we[g], lat_sel[g]}), 32'd0);
      check($sformatf("lat%0d rdata1", g), lat_rdata1[g], 32'd0);
      check($sformatf("lat%0d mem_wdata", g), lat_mem_wdata[g], 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
